// File: rtl/dmx_frame_loader_if.sv
// Byte-stream input and slot-write/status output bundle of the DMX frame loader.
// The loader side uses the slave modport; whoever feeds bytes and watches writes uses master.
interface dmx_frame_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       busy;
    logic       pkt_done;
    logic       pkt_err;

    modport slave (
        input  rx_data, rx_valid,
        output write_addr, write_data, write_en, busy, pkt_done, pkt_err
    );

    modport master (
        output rx_data, rx_valid,
        input  write_addr, write_data, write_en, busy, pkt_done, pkt_err
    );
endinterface

// File: rtl/dmx_frame_loader.sv
// Parses SOF/ADDR/LEN/DATA/CSUM/EOF packets from a UART byte stream and
// writes the DATA bytes into consecutive dmx512 slots.
module dmx_frame_loader #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter logic [7:0] EOF_BYTE       = 8'hE7
) (
    input  logic             clk,
    input  logic             rst_n,
    dmx_frame_loader_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CSUM, S_EOF
    } state_t;

    state_t        state_reg, state_next;
    logic [9:0]    ptr_reg;
    logic [1:0]    hi_reg;
    logic [8:0]    remain_reg;
    logic [7:0]    sum_reg;
    logic          mismatch_reg;
    logic [TW-1:0] timer_reg;

    logic [9:0]    write_addr_reg, write_addr_next;
    logic [7:0]    write_data_reg, write_data_next;
    logic          write_en_reg, write_en_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic          timeout;
    logic          ptr_in_range;

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign timeout      = (state_reg != S_IDLE) && !bus.rx_valid &&
                          (timer_reg == TW'(TIMEOUT_CYCLES));
    assign ptr_in_range = (ptr_reg >= 10'd1) && (ptr_reg <= 10'd512);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            write_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            write_addr_reg <= write_addr_next;
            write_data_reg <= write_data_next;
            write_en_reg   <= write_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = S_IDLE;
        end else if (bus.rx_valid) begin
            case (state_reg)
                S_IDLE:    if (bus.rx_data == SOF_BYTE) state_next = S_ADDR_HI;
                S_ADDR_HI: state_next = S_ADDR_LO;
                S_ADDR_LO: state_next = S_LEN;
                S_LEN:     state_next = S_DATA;
                S_DATA:    if (remain_reg == 9'd1) state_next = S_CSUM;
                S_CSUM:    state_next = S_EOF;
                S_EOF:     state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        write_en_next   = 1'b0;
        write_addr_next = write_addr_reg;
        write_data_next = write_data_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        busy_next       = (state_next != S_IDLE);
        if (timeout) begin
            err_next = 1'b1;
        end else if (bus.rx_valid) begin
            if (state_reg == S_DATA && ptr_in_range) begin
                write_en_next   = 1'b1;
                write_addr_next = ptr_reg;
                write_data_next = bus.rx_data;
            end
            if (state_reg == S_EOF) begin
                if (bus.rx_data == EOF_BYTE && !mismatch_reg) done_next = 1'b1;
                else                                          err_next  = 1'b1;
            end
        end
    end

    // Packet datapath: pointer, remaining count, checksum and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            hi_reg       <= '0;
            remain_reg   <= '0;
            sum_reg      <= '0;
            mismatch_reg <= 1'b0;
            timer_reg    <= '0;
        end else begin
            if (state_reg == S_IDLE || bus.rx_valid)
                timer_reg <= '0;
            else if (timer_reg != TW'(TIMEOUT_CYCLES))
                timer_reg <= timer_reg + 1'b1;

            if (bus.rx_valid) begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.rx_data == SOF_BYTE) begin
                            sum_reg      <= '0;
                            mismatch_reg <= 1'b0;
                        end
                    end
                    S_ADDR_HI: begin
                        hi_reg  <= bus.rx_data[1:0];
                        sum_reg <= sum_reg + bus.rx_data;
                    end
                    S_ADDR_LO: begin
                        ptr_reg <= {hi_reg, bus.rx_data};
                        sum_reg <= sum_reg + bus.rx_data;
                    end
                    S_LEN: begin
                        remain_reg <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                        sum_reg    <= sum_reg + bus.rx_data;
                    end
                    S_DATA: begin
                        if (ptr_reg != 10'd1023) ptr_reg <= ptr_reg + 10'd1;
                        remain_reg <= remain_reg - 9'd1;
                        sum_reg    <= sum_reg + bus.rx_data;
                    end
                    S_CSUM:  mismatch_reg <= (bus.rx_data != sum_reg);
                    default: ;
                endcase
            end
        end
    end

    assign bus.write_addr = write_addr_reg;
    assign bus.write_data = write_data_reg;
    assign bus.write_en   = write_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.pkt_done   = done_reg;
    assign bus.pkt_err    = err_reg;

endmodule

// File: tb/tb_dmx_frame_loader.sv
// Drives framed packets into dmx_frame_loader; expected slot writes and packet
// outcomes go into queues and are matched as the loader produces them.
module tb_dmx_frame_loader;

    localparam int T = 64;

    logic clk = 1'b0;
    logic rst_n;
    dmx_frame_loader_if bus_if ();

    dmx_frame_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [17:0] wq[$];   // {addr, data} of expected slot writes
    bit          rq[$];   // expected outcome: 1 = pkt_done, 0 = pkt_err
    logic [7:0]  pdata [256];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          n;
        logic [31:0] data;      // byte i at bits [8*i +: 8]
        logic [7:0]  csum_xor;  // non-zero corrupts the checksum
        logic [7:0]  eof;
        int          pre;       // garbage bytes sent in IDLE first
        bit          good;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Scoreboard consumer: every write and every outcome pulse must be expected.
    always begin
        @(posedge clk);
        #1;
        if (bus_if.write_en) begin
            if (wq.size() == 0) flag("unexpected_write");
            else chk("write_addr_data", {14'd0, bus_if.write_addr, bus_if.write_data}, {14'd0, wq.pop_front()});
        end
        if (bus_if.pkt_done || bus_if.pkt_err) begin
            chk("done_err_exclusive", {31'd0, bus_if.pkt_done & bus_if.pkt_err}, 32'd0);
            chk("write_vs_result", {31'd0, bus_if.write_en}, 32'd0);
            if (rq.size() == 0) flag("unexpected_result");
            else chk("result_done", {31'd0, bus_if.pkt_done}, {31'd0, rq.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_we);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("write_en_timing", {31'd0, bus_if.write_en}, {31'd0, exp_we});
    endtask

    task automatic settle(input int cycles);
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] hi, input logic [7:0] lo, input int n,
                            input logic [7:0] csum_xor, input logic [7:0] eof,
                            input bit good, input int stall);
        logic [7:0] len8;
        logic [7:0] sum;
        logic [9:0] ptr;
        bit         in_range;
        len8 = n[7:0];
        sum  = hi + lo + len8;
        ptr  = {hi[1:0], lo};
        send_byte(8'h7E, 1'b0);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        if (stall > 0) begin
            @(negedge clk);
            bus_if.rx_valid = 1'b0;
            repeat (stall) @(posedge clk);
        end
        send_byte(len8, 1'b0);
        for (int i = 0; i < n; i++) begin
            in_range = (ptr >= 10'd1) && (ptr <= 10'd512);
            if (in_range) wq.push_back({ptr, pdata[i]});
            sum = sum + pdata[i];
            send_byte(pdata[i], in_range);
            if (ptr != 10'd1023) ptr = ptr + 10'd1;
        end
        send_byte(sum ^ csum_xor, 1'b0);
        rq.push_back(good);
        send_byte(eof, 1'b0);
        settle(3);
        chk("writes_drained", wq.size(), 0);
        chk("results_drained", rq.size(), 0);
        chk("idle_not_busy", {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic load_basic();
        pdata[0] = 8'h10;
        pdata[1] = 8'h20;
        pdata[2] = 8'h30;
    endtask

    vec_t vecs [9];

    initial begin
        // sum(00 05 03 10 20 30) = 0x68; xor 0x21 turns it into the bad 0x49
        vecs[0] = '{8'h00, 8'h05, 3, 32'h0030_2010, 8'h00, 8'hE7, 0, 1'b1};
        vecs[1] = '{8'h00, 8'h05, 3, 32'h0030_2010, 8'h21, 8'hE7, 0, 1'b0};
        vecs[2] = '{8'h01, 8'hFF, 3, 32'h00CC_BBAA, 8'h00, 8'hE7, 0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 2, 32'h0000_2211, 8'h00, 8'hE7, 0, 1'b1};
        vecs[4] = '{8'h00, 8'h10, 1, 32'h0000_0055, 8'h00, 8'h00, 0, 1'b0};
        vecs[5] = '{8'h00, 8'h20, 2, 32'h0000_337E, 8'h00, 8'hE7, 0, 1'b1};
        vecs[6] = '{8'h03, 8'hFF, 2, 32'h0000_0201, 8'h00, 8'hE7, 2, 1'b1};
        vecs[7] = '{8'hFC, 8'h0A, 1, 32'h0000_0099, 8'h00, 8'hE7, 0, 1'b1};
        vecs[8] = '{8'h02, 8'h00, 4, 32'h4433_2211, 8'h00, 8'hE7, 0, 1'b1};

        rst_n           = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_addr", {22'd0, bus_if.write_addr}, 32'd0);
        chk("rst_write_data", {24'd0, bus_if.write_data}, 32'd0);
        chk("rst_write_en",   {31'd0, bus_if.write_en},   32'd0);
        chk("rst_busy",       {31'd0, bus_if.busy},       32'd0);
        chk("rst_pkt_done",   {31'd0, bus_if.pkt_done},   32'd0);
        chk("rst_pkt_err",    {31'd0, bus_if.pkt_err},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(2);

        for (int v = 0; v < 9; v++) begin
            for (int p = 0; p < vecs[v].pre; p++) send_byte(8'h12 + 8'(p), 1'b0);
            for (int i = 0; i < vecs[v].n; i++) pdata[i] = vecs[v].data[8*i +: 8];
            send_pkt(vecs[v].hi, vecs[v].lo, vecs[v].n, vecs[v].csum_xor,
                     vecs[v].eof, vecs[v].good, 0);
            $display("vector %0d: addr=%0d len=%0d good=%0d", v,
                     {vecs[v].hi[1:0], vecs[v].lo}, vecs[v].n, vecs[v].good);
        end

        // LEN byte 0 carries 256 data bytes, slots 256..511
        for (int i = 0; i < 256; i++) pdata[i] = 8'(i * 7 + 3);
        send_pkt(8'h01, 8'h00, 256, 8'h00, 8'hE7, 1'b1, 0);
        $display("len0 packet: 256 slots from 256");

        // Inter-byte stall hits expiry exactly as LEN arrives: byte is kept
        load_basic();
        send_pkt(8'h00, 8'h05, 3, 8'h00, 8'hE7, 1'b1, T);
        $display("byte at timeout boundary accepted");

        // Stall after ADDR_LO until the timeout fires
        send_byte(8'h7E, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        rq.push_back(1'b0);
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        for (int i = 1; i <= T; i++) begin
            @(posedge clk);
            #1;
            if (i == T) begin
                chk("stall_busy_before_expiry", {31'd0, bus_if.busy}, 32'd1);
                chk("stall_no_err_early", {31'd0, bus_if.pkt_err}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        chk("timeout_err", {31'd0, bus_if.pkt_err}, 32'd1);
        chk("timeout_idle", {31'd0, bus_if.busy}, 32'd0);
        settle(2);
        chk("timeout_result_seen", rq.size(), 0);
        load_basic();
        send_pkt(8'h00, 8'h05, 3, 8'h00, 8'hE7, 1'b1, 0);
        $display("timeout then fresh packet");

        // Reset in the middle of DATA after two of four bytes
        send_byte(8'h7E, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h04, 1'b0);
        wq.push_back({10'd5, 8'hA1});
        send_byte(8'hA1, 1'b1);
        wq.push_back({10'd6, 8'hA2});
        send_byte(8'hA2, 1'b1);
        @(negedge clk);
        rst_n           = 1'b0;
        bus_if.rx_valid = 1'b0;
        #1;
        chk("mid_rst_write_addr", {22'd0, bus_if.write_addr}, 32'd0);
        chk("mid_rst_write_data", {24'd0, bus_if.write_data}, 32'd0);
        chk("mid_rst_write_en",   {31'd0, bus_if.write_en},   32'd0);
        chk("mid_rst_busy",       {31'd0, bus_if.busy},       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_write", {31'd0, bus_if.write_en}, 32'd0);
            chk("post_rst_idle", {31'd0, bus_if.busy}, 32'd0);
        end
        chk("mid_rst_writes_drained", wq.size(), 0);
        load_basic();
        send_pkt(8'h00, 8'h05, 3, 8'h00, 8'hE7, 1'b1, 0);
        $display("reset mid-packet then fresh packet");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
